// File: rtl/scale_coord_gen.sv
// Source-coordinate generator for the video scaler: per-frame sequential ratio divider, then a
// stallable 2-stage valid/ready pipeline mapping output pixels to clamped source coords and weights.
module scale_coord_gen #(
  parameter int RES_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic              vin_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              mode,
  input  logic [RES_W-1:0]  vin_xres,
  input  logic [RES_W-1:0]  vin_yres,
  input  logic [RES_W-1:0]  vout_xres,
  input  logic [RES_W-1:0]  vout_yres,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RES_W-1:0]  req_x,
  input  logic [RES_W-1:0]  req_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  coord_x,
  output logic [RES_W-1:0]  coord_y,
  output logic [FRAC_W:0]   coef1,
  output logic [FRAC_W:0]   coef2,
  output logic [FRAC_W:0]   coef3,
  output logic [FRAC_W:0]   coef4
);

  localparam int DIV_W  = RES_W + FRAC_W;
  localparam int PROD_W = RES_W + 1 + DIV_W;
  localparam int SRC_W  = PROD_W - 1;
  localparam int CNT_W  = $clog2(DIV_W + 1);
  localparam int COEF_W = FRAC_W + 1;
  localparam int S1_W   = 1 + RES_W + FRAC_W;
  localparam int S2_W   = RES_W + 2 * COEF_W;

  localparam logic [COEF_W-1:0] ONE      = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [PROD_W-1:0] PROD_ONE = {{(PROD_W-1){1'b0}}, 1'b1};
  localparam logic [RES_W-1:0]  RES_ONE  = {{(RES_W-1){1'b0}}, 1'b1};
  localparam logic [RES_W-1:0]  RES_TWO  = {{(RES_W-2){1'b0}}, 2'd2};
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } state_t;

  // One restoring-division step: returns {quotient bit, new remainder}.
  function automatic logic [RES_W:0] div_step(input logic [RES_W-1:0] rem,
                                               input logic             din,
                                               input logic [RES_W-1:0] dvsr);
    logic [RES_W:0]   sh;
    logic [RES_W-1:0] diff;
    sh   = {rem, din};
    diff = sh[RES_W-1:0] - dvsr;
    if (sh >= {1'b0, dvsr}) div_step = {1'b1, diff};
    else                    div_step = {1'b0, sh[RES_W-1:0]};
  endfunction

  // Half-pixel centred source position: returns {overflow, ipart, frac}.
  function automatic logic [S1_W-1:0] stage1(input logic [RES_W-1:0] req,
                                             input logic [DIV_W-1:0] scale);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_m1;
    logic [SRC_W-1:0]  src;
    prod = {{DIV_W{1'b0}}, req, 1'b1} * {{(RES_W+1){1'b0}}, scale};
    if (prod == {PROD_W{1'b0}}) prod_m1 = {PROD_W{1'b0}};
    else                        prod_m1 = prod - PROD_ONE;
    src    = SRC_W'(prod_m1 >> 1);
    stage1 = {|src[SRC_W-1:FRAC_W+RES_W], src[FRAC_W+RES_W-1:0]};
  endfunction

  // Edge clamp and weight generation: returns {coord, coef_lo, coef_hi}.
  function automatic logic [S2_W-1:0] map_axis(input logic [RES_W-1:0]  ipart,
                                               input logic [FRAC_W-1:0] frac,
                                               input logic              ovf,
                                               input logic [RES_W-1:0]  in_res,
                                               input logic              nearest);
    logic [RES_W:0]    ip1;
    logic [RES_W:0]    near;
    logic [RES_W:0]    lim;
    logic [RES_W-1:0]  coord;
    logic [COEF_W-1:0] lo;
    logic [COEF_W-1:0] hi;
    ip1  = {1'b0, ipart} + {1'b0, RES_ONE};
    near = {1'b0, ipart} + {{RES_W{1'b0}}, frac[FRAC_W-1]};
    lim  = {1'b0, in_res} - {1'b0, RES_ONE};
    if (nearest) begin
      lo = ONE;
      hi = {COEF_W{1'b0}};
      if (in_res == {RES_W{1'b0}})  coord = {RES_W{1'b0}};
      else if (ovf || (near > lim)) coord = lim[RES_W-1:0];
      else                          coord = near[RES_W-1:0];
    end else if (ovf || (ip1 >= {1'b0, in_res})) begin
      hi = ONE;
      lo = {COEF_W{1'b0}};
      if (in_res < RES_TWO) coord = {RES_W{1'b0}};
      else                  coord = in_res - RES_TWO;
    end else begin
      coord = ipart;
      hi    = {1'b0, frac};
      lo    = ONE - {1'b0, frac};
    end
    map_axis = {coord, lo, hi};
  endfunction

  state_t            state_r, state_nx_s;
  logic              mode_r;
  logic [RES_W-1:0]  in_xres_r, in_yres_r, dvsr_x_r, dvsr_y_r, rem_x_r, rem_y_r;
  logic [DIV_W-1:0]  divd_x_r, divd_y_r, scale_x_r, scale_y_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [RES_W:0]    step_x_s, step_y_s;
  logic              div_done_s, div_zero_s;
  logic              cfg_ready_r, cfg_err_r;
  logic              stall_s, accept_s, req_ready_s;
  logic [S1_W-1:0]   s1_x_s, s1_y_s, s1_x_r, s1_y_r;
  logic              s1_valid_r;
  logic [S2_W-1:0]   s2_x_s, s2_y_s, s2_x_r, s2_y_r;
  logic              s2_valid_r;

  assign div_done_s = (cnt_r == DIV_LAST);
  assign div_zero_s = (dvsr_x_r == {RES_W{1'b0}}) || (dvsr_y_r == {RES_W{1'b0}});

  // Configuration FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    if (frame_start) begin
      state_nx_s = DIV;
    end else begin
      case (state_r)
        DIV: begin
          if (div_done_s) state_nx_s = div_zero_s ? ERR : READY;
          else            state_nx_s = state_r;
        end
        default: state_nx_s = state_r;
      endcase
    end
  end

  // FSM state register with registered status flags.
  always_ff @(posedge vin_clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cfg_ready_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cfg_ready_r <= (state_nx_s == READY);
      cfg_err_r   <= (state_nx_s == ERR);
    end
  end

  assign step_x_s = div_step(rem_x_r, divd_x_r[DIV_W-1], dvsr_x_r);
  assign step_y_s = div_step(rem_y_r, divd_y_r[DIV_W-1], dvsr_y_r);

  // Latch frame configuration and run both dividers one quotient bit per cycle.
  always_ff @(posedge vin_clk) begin
    if (!rst_n) begin
      mode_r    <= 1'b0;
      in_xres_r <= {RES_W{1'b0}};
      in_yres_r <= {RES_W{1'b0}};
      dvsr_x_r  <= {RES_W{1'b0}};
      dvsr_y_r  <= {RES_W{1'b0}};
      rem_x_r   <= {RES_W{1'b0}};
      rem_y_r   <= {RES_W{1'b0}};
      divd_x_r  <= {DIV_W{1'b0}};
      divd_y_r  <= {DIV_W{1'b0}};
      scale_x_r <= {DIV_W{1'b0}};
      scale_y_r <= {DIV_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (frame_start) begin
      mode_r    <= mode;
      in_xres_r <= vin_xres;
      in_yres_r <= vin_yres;
      dvsr_x_r  <= vout_xres;
      dvsr_y_r  <= vout_yres;
      rem_x_r   <= {RES_W{1'b0}};
      rem_y_r   <= {RES_W{1'b0}};
      divd_x_r  <= {vin_xres, {FRAC_W{1'b0}}};
      divd_y_r  <= {vin_yres, {FRAC_W{1'b0}}};
      scale_x_r <= {DIV_W{1'b0}};
      scale_y_r <= {DIV_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (state_r == DIV) begin
      rem_x_r   <= step_x_s[RES_W-1:0];
      rem_y_r   <= step_y_s[RES_W-1:0];
      divd_x_r  <= {divd_x_r[DIV_W-2:0], 1'b0};
      divd_y_r  <= {divd_y_r[DIV_W-2:0], 1'b0};
      scale_x_r <= {scale_x_r[DIV_W-2:0], step_x_s[RES_W]};
      scale_y_r <= {scale_y_r[DIV_W-2:0], step_y_s[RES_W]};
      cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_s     = s2_valid_r && !out_ready;
  assign req_ready_s = (state_r == READY) && !stall_s;
  assign accept_s    = req_valid && req_ready_s;

  assign s1_x_s = stage1(req_x, scale_x_r);
  assign s1_y_s = stage1(req_y, scale_y_r);
  assign s2_x_s = map_axis(s1_x_r[FRAC_W+RES_W-1:FRAC_W], s1_x_r[FRAC_W-1:0],
                           s1_x_r[S1_W-1], in_xres_r, mode_r);
  assign s2_y_s = map_axis(s1_y_r[FRAC_W+RES_W-1:FRAC_W], s1_y_r[FRAC_W-1:0],
                           s1_y_r[S1_W-1], in_yres_r, mode_r);

  // Two-stage mapping pipeline; a frame restart drops anything in flight.
  always_ff @(posedge vin_clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s1_x_r     <= {S1_W{1'b0}};
      s1_y_r     <= {S1_W{1'b0}};
      s2_x_r     <= {S2_W{1'b0}};
      s2_y_r     <= {S2_W{1'b0}};
    end else if (frame_start) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      s2_valid_r <= s1_valid_r;
      if (accept_s) begin
        s1_x_r <= s1_x_s;
        s1_y_r <= s1_y_s;
      end
      if (s1_valid_r) begin
        s2_x_r <= s2_x_s;
        s2_y_r <= s2_y_s;
      end
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign req_ready = req_ready_s;
  assign out_valid = s2_valid_r;
  assign coord_x   = s2_x_r[S2_W-1 -: RES_W];
  assign coef1     = s2_x_r[2*COEF_W-1 -: COEF_W];
  assign coef2     = s2_x_r[COEF_W-1:0];
  assign coord_y   = s2_y_r[S2_W-1 -: RES_W];
  assign coef3     = s2_y_r[2*COEF_W-1 -: COEF_W];
  assign coef4     = s2_y_r[COEF_W-1:0];

endmodule

// File: tb/tb_scale_coord_gen.sv
// Bench for scale_coord_gen: arithmetic reference model with an every-cycle scoreboard,
// plus directed scenarios pinned to hand-computed values.
module tb_scale_coord_gen;

  localparam int RES_W  = 16;
  localparam int FRAC_W = 16;
  localparam longint ONE = 65536;

  logic              vin_clk = 1'b0;
  logic              rst_n, frame_start, mode;
  logic [RES_W-1:0]  vin_xres, vin_yres, vout_xres, vout_yres;
  logic              cfg_ready, cfg_err;
  logic              req_valid, req_ready;
  logic [RES_W-1:0]  req_x, req_y;
  logic              out_valid, out_ready;
  logic [RES_W-1:0]  coord_x, coord_y;
  logic [FRAC_W:0]   coef1, coef2, coef3, coef4;

  always #5 vin_clk = ~vin_clk;

  scale_coord_gen #(.RES_W(RES_W), .FRAC_W(FRAC_W)) dut (
    .vin_clk(vin_clk), .rst_n(rst_n), .frame_start(frame_start), .mode(mode),
    .vin_xres(vin_xres), .vin_yres(vin_yres), .vout_xres(vout_xres), .vout_yres(vout_yres),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .coord_x(coord_x), .coord_y(coord_y),
    .coef1(coef1), .coef2(coef2), .coef3(coef3), .coef4(coef4)
  );

  typedef struct { longint cx, cy, c1, c2, c3, c4; } exp_t;

  int     n_cmp = 0;
  int     n_err = 0;
  int     n_out = 0;
  exp_t   sb_q[$];
  longint m_inx, m_iny, m_outx, m_outy;
  bit     m_mode;
  bit     hold_v = 1'b0;
  longint hold_x, hold_y;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint m_scale(input longint inr, input longint outr);
    return (outr == 0) ? 0 : (inr * ONE) / outr;
  endfunction

  // Per-axis mapping from the arithmetic definition of the scaler.
  function automatic void m_axis(input longint req, input longint inr, input longint sc,
                                 input bit nearest, output longint coord,
                                 output longint lo, output longint hi);
    longint prod, src, ip, fr, n;
    bit     ovf;
    prod = (2 * req + 1) * sc;
    src  = (prod == 0) ? 0 : (prod - 1) / 2;
    ip   = (src / ONE) % 65536;
    fr   = src % ONE;
    ovf  = (src / (ONE * 65536)) != 0;
    if (nearest) begin
      lo = ONE;
      hi = 0;
      n  = ip + ((fr >= ONE / 2) ? 1 : 0);
      if (inr == 0)                    coord = 0;
      else if (ovf || n > inr - 1)     coord = inr - 1;
      else                             coord = n;
    end else if (ovf || ip >= inr - 1) begin
      coord = (inr < 2) ? 0 : inr - 2;
      hi = ONE;
      lo = 0;
    end else begin
      coord = ip;
      hi = fr;
      lo = ONE - fr;
    end
  endfunction

  function automatic exp_t m_result(input longint rx, input longint ry);
    exp_t e;
    m_axis(rx, m_inx, m_scale(m_inx, m_outx), m_mode, e.cx, e.c1, e.c2);
    m_axis(ry, m_iny, m_scale(m_iny, m_outy), m_mode, e.cy, e.c3, e.c4);
    return e;
  endfunction

  // Scoreboard: every transfer is predicted, every delivered result is checked, stalls hold.
  always @(negedge vin_clk) begin
    if (!rst_n) begin
      sb_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_x", {coord_x, coef1, coef2}, hold_x);
        chk("stall_y", {coord_y, coef3, coef4}, hold_y);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: result coord_x=%0d delivered, none pending", coord_x);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("coord_x", coord_x, e.cx);
          chk("coord_y", coord_y, e.cy);
          chk("coef1", coef1, e.c1);
          chk("coef2", coef2, e.c2);
          chk("coef3", coef3, e.c3);
          chk("coef4", coef4, e.c4);
          n_out++;
        end
      end
      if (frame_start) sb_q.delete();
      else if (req_valid && req_ready) sb_q.push_back(m_result(req_x, req_y));
      hold_v = out_valid && !out_ready && !frame_start;
      hold_x = {coord_x, coef1, coef2};
      hold_y = {coord_y, coef3, coef4};
    end
  end

  task automatic tick();
    @(posedge vin_clk);
    #1;
  endtask

  // Pulse frame_start and return the cycle (relative to the pulse) when config resolves.
  task automatic start_frame(input longint ix, input longint iy, input longint ox,
                             input longint oy, input bit md, output int cyc);
    vin_xres = RES_W'(ix); vin_yres = RES_W'(iy);
    vout_xres = RES_W'(ox); vout_yres = RES_W'(oy);
    mode = md; frame_start = 1'b1;
    m_inx = ix; m_iny = iy; m_outx = ox; m_outy = oy; m_mode = md;
    tick();
    frame_start = 1'b0;
    req_valid = 1'b0;
    cyc = 1;
    chk("restart_out_valid", out_valid, 0);
    chk("restart_cfg_ready", cfg_ready, 0);
    while (!cfg_ready && !cfg_err && cyc < 100) begin
      if (cyc == 5) chk("req_ready_in_div", req_ready, 0);
      tick();
      cyc++;
    end
  endtask

  task automatic send_req(input longint x, input longint y);
    req_x = RES_W'(x); req_y = RES_W'(y); req_valid = 1'b1;
    #1;
    chk("req_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("latency_n1", out_valid, 0);
    tick();
    chk("latency_n2", out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, idx, n0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; frame_start = 1'b0; mode = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_x = '0; req_y = '0; vin_xres = '0; vin_yres = '0; vout_xres = '0; vout_yres = '0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_coords", {coord_x, coord_y}, 0);
    chk("rst_coefs", {coef1, coef2, coef3}, 0);
    rst_n = 1'b1;
    tick();

    // Downscale 1920x1080 -> 1280x720, bilinear
    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    chk("ready_cycle_down", cyc, 33);
    chk("down_cfg_err", cfg_err, 0);
    send_req(0, 0);
    chk("down_x0_coord", coord_x, 0);
    chk("down_x0_coef2", coef2, 49151);
    chk("down_x0_coef1", coef1, 16385);
    chk("down_y0_coef4", coef4, 49151);
    send_req(1279, 719);
    chk("edge_coord_x", coord_x, 1918);
    chk("edge_coef2", coef2, 65536);
    chk("edge_coef1", coef1, 0);
    chk("edge_coord_y", coord_y, 1078);

    // Upscale 640x480 -> 1280x960, bilinear then nearest
    start_frame(640, 480, 1280, 960, 1'b0, cyc);
    chk("ready_cycle_up", cyc, 33);
    send_req(0, 0);
    chk("up_y0_coord", coord_y, 0);
    chk("up_y0_coef4", coef4, 16383);
    chk("up_y0_coef3", coef3, 49153);
    start_frame(640, 480, 1280, 960, 1'b1, cyc);
    send_req(3, 0);
    chk("near_x3_coord", coord_x, 2);
    chk("near_x3_coef1", coef1, 65536);
    chk("near_x3_coef2", coef2, 0);

    // Back-pressure stream x=0..7 with out_ready cycling 1,0,0,1
    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    idx = 0; cyc = 0; n0 = n_out;
    while ((idx < 8 || sb_q.size() != 0) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      req_valid = (idx < 8);
      req_x = RES_W'(idx); req_y = RES_W'(7 - idx);
      @(negedge vin_clk);
      if (req_valid && req_ready) idx++;
      tick();
      cyc++;
    end
    req_valid = 1'b0; out_ready = 1'b1;
    chk("stream_done_in_budget", (cyc < 200) ? 1 : 0, 1);
    chk("stream_count", n_out - n0, 8);

    // Divide-by-zero, then recovery
    start_frame(1920, 1080, 0, 720, 1'b0, cyc);
    chk("err_cycle", cyc, 33);
    chk("err_flag", cfg_err, 1);
    chk("err_cfg_ready", cfg_ready, 0);
    req_valid = 1'b1;
    #1;
    chk("err_req_ready", req_ready, 0);
    req_valid = 1'b0;
    repeat (5) tick();
    chk("err_sticky", cfg_err, 1);
    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    chk("recover_cycle", cyc, 33);
    chk("recover_err_clr", cfg_err, 0);

    // frame_start together with a transferable request: request is dropped
    n0 = n_out;
    req_valid = 1'b1; req_x = 16'd5; req_y = 16'd5;
    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    repeat (3) tick();
    chk("same_cycle_discard", n_out - n0, 0);

    // Mid-stream restart with two results in flight
    out_ready = 1'b0;
    req_valid = 1'b1; req_x = 16'd10; req_y = 16'd10;
    tick();
    req_x = 16'd11;
    tick();
    req_valid = 1'b0;
    chk("inflight_valid", out_valid, 1);
    n0 = n_out;
    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    chk("restart_ready_cycle", cyc, 33);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("restart_discard", n_out - n0, 0);

    // Reset during DIV overrides a simultaneous frame_start
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0; frame_start = 1'b1;
    tick();
    chk("div_rst_out_valid", out_valid, 0);
    chk("div_rst_req_ready", req_ready, 0);
    chk("div_rst_x", {coord_x, coef1, coef2}, 0);
    chk("div_rst_y", {coord_y, coef3, coef4}, 0);
    rst_n = 1'b1; frame_start = 1'b0;
    repeat (40) tick();
    chk("idle_after_rst", {cfg_ready, cfg_err}, 0);

    start_frame(1920, 1080, 1280, 720, 1'b0, cyc);
    chk("post_rst_cycle", cyc, 33);
    send_req(0, 0);
    chk("post_rst_coef2", coef2, 49151);
    repeat (3) tick();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
